// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: time-multiplexed controller for the 9-tap symmetric FIR.
// One shared external adder (add_a + add_b -> add_o, combinational) forms all
// eight tap sums. Each sample takes eight accumulate steps. The operand order
// follows the parallel chain, so approximate-adder error matches that chain
// bit for bit.
module fir_tap_sequencer #(
  parameter int W  = 16,
  parameter int H4 = 32,
  parameter int H3 = 18,
  parameter int H2 = 6,
  parameter int H1 = 0,
  parameter int H0 = 2
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_o,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } stateT;

  stateT        state;
  logic [W-1:0] taps [9];
  logic [W-1:0] acc;
  logic [2:0]   step;

  logic [3:0]   aIdx;
  logic [W-1:0] prodA;
  logic [W-1:0] prodB;

  // Symmetric coefficient table; the centre tap is the only negative one.
  function automatic logic [W-1:0] coefOf(input logic [3:0] idx);
    logic [W-1:0] c;
    case (idx)
      4'd0, 4'd8: c = W'(H4);
      4'd1, 4'd7: c = W'(H3);
      4'd2, 4'd6: c = W'(H2);
      4'd3, 4'd5: c = W'(H1);
      4'd4:       c = W'(-H0);
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Pick this step's tap products and drive the shared adder, idle outside RUN.
  always_comb begin
    aIdx  = (step == 3'd0) ? 4'd0 : ({1'b0, step} + 4'd1);
    prodA = coefOf(aIdx) * taps[aIdx];
    prodB = coefOf(4'd1) * taps[1];
    add_a = '0;
    add_b = '0;
    if (state == RUN) begin
      add_a = prodA;
      add_b = (step == 3'd0) ? prodB : acc;
    end
  end

  // Control FSM: shift the window, then run 8 accumulate steps, then hold y until taken.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      for (int i = 0; i < 9; i++) taps[i] <= '0;
      acc       <= '0;
      step      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            taps[0] <= x;
            for (int i = 1; i < 9; i++) taps[i] <= taps[i-1];
            step     <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= add_o;
          if (step == 3'd7) begin
            y         <= add_o;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            step <= step + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: drives fir_tap_sequencer with an exact adder on
// add_*, then checks operands, outputs and handshakes against a window/array
// reference model of the symmetric FIR.
module tb_fir_tap_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rstN = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] x = '0;
  logic         in_ready;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] add_o;
  logic         out_valid;
  logic [W-1:0] y;

  int testCount = 0;
  int failCount = 0;

  int           coef [9] = '{32, 18, 6, 0, -2, 0, 6, 18, 32};
  int           hist [9];
  logic [W-1:0] obsA [8];
  logic [W-1:0] obsB [8];

  fir_tap_sequencer dut (
    .clk       (clk),
    .rstN      (rstN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_o     (add_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  // Exact adder stands in for the approximate one.
  assign add_o = add_a + add_b;

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Hard stop in case something hangs.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] prod(input int i);
    return 16'(coef[i] * hist[i]);
  endfunction

  function automatic logic [W-1:0] expectedY();
    logic [W-1:0] sum;
    sum = '0;
    for (int i = 0; i < 9; i++) sum = sum + prod(i);
    return sum;
  endfunction

  task automatic modelAccept(input logic [W-1:0] s);
    for (int i = 8; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'($signed(s));
  endtask

  task automatic modelClear();
    for (int i = 0; i < 9; i++) hist[i] = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    modelClear();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  // One sample end to end: accept, 8 RUN steps, output, optional backpressure.
  task automatic applyStimulus(input logic [W-1:0] s, input int hold, output logic [W-1:0] yObs);
    logic [W-1:0] running;
    logic [W-1:0] expA;
    logic [W-1:0] expB;
    int waitCnt;
    yObs = '0;
    @(negedge clk);
    x = s;
    in_valid = 1'b1;
    out_ready = 1'b1;
    waitCnt = 0;
    while (!in_ready && waitCnt < 30) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 16'd0, 16'd1);
      in_valid = 1'b0;
      return;
    end
    modelAccept(s);
    @(negedge clk);
    in_valid = 1'b0;
    running = '0;
    for (int k = 0; k < 8; k++) begin
      expA = (k == 0) ? prod(0) : prod(k + 1);
      expB = (k == 0) ? prod(1) : running;
      obsA[k] = add_a;
      obsB[k] = add_b;
      checkOutput($sformatf("step%0d_add_a", k), add_a, expA);
      checkOutput($sformatf("step%0d_add_b", k), add_b, expB);
      checkOutput("run_in_ready", 16'(in_ready), 16'd0);
      checkOutput("run_out_valid", 16'(out_valid), 16'd0);
      running = expA + expB;
      @(negedge clk);
    end
    checkOutput("latency_out_valid", 16'(out_valid), 16'd1);
    checkOutput("y", y, running);
    checkOutput("y_model", y, expectedY());
    yObs = y;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      x = 16'($urandom);
      @(negedge clk);
      checkOutput("bp_out_valid", 16'(out_valid), 16'd1);
      checkOutput("bp_y", y, yObs);
      checkOutput("bp_in_ready", 16'(in_ready), 16'd0);
      checkOutput("bp_add_a", add_a, 16'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("idle_out_valid", 16'(out_valid), 16'd0);
    checkOutput("idle_in_ready", 16'(in_ready), 16'd1);
    checkOutput("idle_y_held", y, yObs);
  endtask

  // Scenario sequence.
  initial begin
    logic [W-1:0] yTmp;
    int impulse [9] = '{32, 18, 6, 0, -2, 0, 6, 18, 32};
    logic [W-1:0] stream [$];
    int lastAccept;
    int accepts;

    modelClear();
    #1 rstN = 1'b0;
    #1;
    checkOutput("reset_in_ready", 16'(in_ready), 16'd1);
    checkOutput("reset_out_valid", 16'(out_valid), 16'd0);
    checkOutput("reset_y", y, 16'd0);
    checkOutput("reset_add_a", add_a, 16'd0);
    checkOutput("reset_add_b", add_b, 16'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    // Impulse response walks through the coefficient list.
    for (int i = 0; i < 9; i++) begin
      applyStimulus((i == 0) ? 16'd1 : 16'd0, 0, yTmp);
      checkOutput($sformatf("impulse_%0d", i), yTmp, 16'(impulse[i]));
    end

    // Window 1..9 with 9 newest: 288+144+42+0-10+0+18+36+32 = 550.
    doReset();
    for (int i = 1; i <= 9; i++) applyStimulus(16'(i), 0, yTmp);
    checkOutput("order_step0_a", obsA[0], 16'd288);
    checkOutput("order_step0_b", obsB[0], 16'd144);
    checkOutput("order_step1_a", obsA[1], 16'd42);
    checkOutput("order_step1_b", obsB[1], 16'd432);
    checkOutput("order_y", yTmp, 16'd550);

    // Product wraps instead of saturating.
    doReset();
    applyStimulus(16'h7FFF, 0, yTmp);
    checkOutput("wrap_p0", obsA[0], 16'hFFE0);
    checkOutput("wrap_y", yTmp, 16'hFFE0);

    // Backpressure in DONE for 5 cycles while x toggles.
    applyStimulus(16'd3, 5, yTmp);
    applyStimulus(16'd0, 0, yTmp);

    // Reset in the middle of RUN aborts the sample and clears the window.
    doReset();
    applyStimulus(16'd1000, 0, yTmp);
    checkOutput("pre_reset_y", yTmp, 16'd32000);
    @(negedge clk);
    x = 16'd5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("midrun_in_ready", 16'(in_ready), 16'd1);
    checkOutput("midrun_out_valid", 16'(out_valid), 16'd0);
    checkOutput("midrun_y", y, 16'd0);
    checkOutput("midrun_add_a", add_a, 16'd0);
    modelClear();
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(16'd1, 0, yTmp);
    checkOutput("post_reset_impulse", yTmp, 16'd32);

    // Random samples with random backpressure.
    for (int i = 0; i < 12; i++) applyStimulus(16'($urandom), int'($urandom_range(0, 3)), yTmp);

    // Back-to-back stream: accept every 10 cycles, outputs follow the convolution.
    lastAccept = -1;
    accepts = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      x = 16'($urandom);
      in_valid = 1'b1;
      if (out_valid) begin
        if (stream.size() == 0) checkOutput("stream_unexpected", y, 16'd0 - 16'd1);
        else checkOutput("stream_y", y, stream.pop_front());
      end
      if (in_ready) begin
        modelAccept(x);
        stream.push_back(expectedY());
        if (lastAccept >= 0) checkOutput("accept_gap", 16'(cyc - lastAccept), 16'd10);
        lastAccept = cyc;
        accepts++;
      end
    end
    for (int d = 0; d < 25 && stream.size() != 0; d++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) checkOutput("drain_y", y, stream.pop_front());
    end
    in_valid = 1'b0;
    checkOutput("stream_accepts", 16'(accepts), 16'd10);
    checkOutput("drain_empty", 16'(stream.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
